// File: rtl/alu_sched_pkg.sv
// Shared types and default sizing for the ALU scheduler.
package alu_sched_pkg;

  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned DEF_OP_W    = 4;
  localparam int unsigned DEF_RES_W   = 2 * DEF_DATA_W;
  localparam int unsigned DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic [DEF_OP_W-1:0]   op;
    logic [DEF_DATA_W-1:0] a;
    logic [DEF_DATA_W-1:0] b;
  } req_t;

endpackage

// File: rtl/alu_sched_if.sv
// Request, response and ALU handshake signals for the ALU scheduler.
interface alu_sched_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned RES_W  = 16
);

  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [OP_W-1:0]   req0_op, req1_op;
  logic [DATA_W-1:0] req0_a, req1_a;
  logic [DATA_W-1:0] req0_b, req1_b;

  logic              rsp0_valid, rsp1_valid;
  logic              rsp0_ready, rsp1_ready;
  logic [RES_W-1:0]  rsp0_result, rsp1_result;
  logic              rsp0_err, rsp1_err;

  logic              alu_start;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_a, alu_b;
  logic              alu_done;
  logic [RES_W-1:0]  alu_result;

  // Environment side: requesters plus the ALU under test.
  modport master (
    output req0_valid, req1_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b,
    output rsp0_ready, rsp1_ready, alu_done, alu_result,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    input  rsp0_result, rsp1_result, rsp0_err, rsp1_err,
    input  alu_start, alu_op, alu_a, alu_b
  );

  // Scheduler side.
  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b,
    input  rsp0_ready, rsp1_ready, alu_done, alu_result,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
    output rsp0_result, rsp1_result, rsp0_err, rsp1_err,
    output alu_start, alu_op, alu_a, alu_b
  );

endinterface

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin winner select; the requester not served last wins a tie.
module alu_rr_arb2 (
  input  logic [1:0] valid,
  input  logic       rr_last,
  output logic       gnt_valid,
  output logic       gnt_id
);

  // Pick the sole requester, or alternate against rr_last on a tie.
  always_comb begin
    gnt_valid = |valid;
    gnt_id    = 1'b0;
    if (&valid) gnt_id = ~rr_last;
    else        gnt_id = valid[1];
  end

endmodule

// File: rtl/alu_sched.sv
// Shares one multicycle ALU between two requesters with round-robin grant,
// a start/done ALU handshake and a timeout-protected response channel.
module alu_sched
  import alu_sched_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned OP_W    = DEF_OP_W,
  parameter int unsigned RES_W   = DEF_RES_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_sched_if.slave  bus,
  output logic        busy,
  output logic        grant_id
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic              rr_last_q, grant_q, err_q;
  logic              gnt_valid, gnt_id, accept, rsp_take;
  logic [7:0]        cnt_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic [RES_W-1:0]  res_q;

  alu_rr_arb2 u_arb (
    .valid     ({bus.req1_valid, bus.req0_valid}),
    .rr_last   (rr_last_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Ready is combinational in IDLE; gating with rst_n keeps it low while in reset.
  assign accept   = rst_n && (state_q == IDLE) && gnt_valid;
  assign rsp_take = (state_q == RESP) && (grant_q ? bus.rsp1_ready : bus.rsp0_ready);

  assign busy       = (state_q != IDLE);
  assign grant_id   = grant_q;
  assign bus.alu_op = op_q;
  assign bus.alu_a  = a_q;
  assign bus.alu_b  = b_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; alu_done takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (bus.alu_done || (cnt_q == TO_LAST)) state_d = RESP;
      RESP:    if (rsp_take) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the current state.
  always_comb begin
    bus.req0_ready  = accept && !gnt_id;
    bus.req1_ready  = accept && gnt_id;
    bus.alu_start   = (state_q == ISSUE);
    bus.rsp0_valid  = 1'b0;
    bus.rsp1_valid  = 1'b0;
    bus.rsp0_result = '0;
    bus.rsp1_result = '0;
    bus.rsp0_err    = 1'b0;
    bus.rsp1_err    = 1'b0;
    if (state_q == RESP) begin
      if (grant_q) begin
        bus.rsp1_valid  = 1'b1;
        bus.rsp1_result = res_q;
        bus.rsp1_err    = err_q;
      end else begin
        bus.rsp0_valid  = 1'b1;
        bus.rsp0_result = res_q;
        bus.rsp0_err    = err_q;
      end
    end
  end

  // Operand capture, timeout counter, result capture and round-robin history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      grant_q   <= 1'b0;
      cnt_q     <= '0;
      res_q     <= '0;
      err_q     <= 1'b0;
      rr_last_q <= 1'b1;
    end else begin
      if (accept) begin
        op_q    <= gnt_id ? bus.req1_op : bus.req0_op;
        a_q     <= gnt_id ? bus.req1_a  : bus.req0_a;
        b_q     <= gnt_id ? bus.req1_b  : bus.req0_b;
        grant_q <= gnt_id;
      end
      if (state_q == ISSUE) cnt_q <= '0;
      if (state_q == WAIT) begin
        if (bus.alu_done) begin
          res_q <= bus.alu_result;
          err_q <= 1'b0;
        end else if (cnt_q == TO_LAST) begin
          res_q <= '0;
          err_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end
      if (rsp_take) rr_last_q <= grant_q;
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: a behavioural ALU with programmable done delay,
// expected responses queued at accept time and compared at response handshake.
module tb_alu_sched;
  import alu_sched_pkg::*;

  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, grant_id;

  alu_sched_if #(.DATA_W(8), .OP_W(4), .RES_W(16)) bus ();

  alu_sched #(.DATA_W(8), .OP_W(4), .RES_W(16), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        id;
    logic [15:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];
  logic acc_ids[$];
  int   n_checks = 0, n_errors = 0;
  int   cyc = 0, n_acc = 0, n_rsp = 0, n_start = 0;
  int   acc_cyc = 0, start_cyc = 0, rsp_cyc = 0, drv_cyc = 0;
  logic prev_rsp = 1'b0;
  req_t last_req;
  logic last_id = 1'b0;

  // ALU model controls: delay 0 means done never comes.
  int          alu_delay = 1;
  int          cd = 0;
  logic        inject = 1'b0;
  logic [15:0] res_hold = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'd0:    return 16'(a) + 16'(b);
      4'd1:    return 16'(a) - 16'(b);
      4'd2:    return 16'(a) * 16'(b);
      default: return 16'(a ^ b);
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural ALU.
  always @(posedge clk) begin
    bus.alu_done <= 1'b0;
    if (inject) begin
      bus.alu_done   <= 1'b1;
      bus.alu_result <= 16'hDEAD;
    end else if (bus.alu_start && alu_delay != 0) begin
      if (alu_delay == 1) begin
        bus.alu_done   <= 1'b1;
        bus.alu_result <= alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
      end else begin
        cd       <= alu_delay - 1;
        res_hold <= alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
      end
    end else if (cd != 0) begin
      cd <= cd - 1;
      if (cd == 1) begin
        bus.alu_done   <= 1'b1;
        bus.alu_result <= res_hold;
      end
    end
  end

  function automatic exp_t mk_exp(input logic id, input req_t r);
    exp_t e;
    e.id  = id;
    e.err = (alu_delay == 0) || (alu_delay > TMO);
    e.res = e.err ? 16'h0 : alu_f(r.op, r.a, r.b);
    return e;
  endfunction

  // Monitor: push on accept, check issue, pop and compare on response handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.req0_valid && bus.req0_ready) begin
        last_req = '{op: bus.req0_op, a: bus.req0_a, b: bus.req0_b};
        last_id = 1'b0;
        sb.push_back(mk_exp(1'b0, last_req));
        acc_ids.push_back(1'b0);
        acc_cyc = cyc;
        n_acc++;
      end
      if (bus.req1_valid && bus.req1_ready) begin
        last_req = '{op: bus.req1_op, a: bus.req1_a, b: bus.req1_b};
        last_id = 1'b1;
        sb.push_back(mk_exp(1'b1, last_req));
        acc_ids.push_back(1'b1);
        acc_cyc = cyc;
        n_acc++;
      end
      if (bus.alu_start) begin
        start_cyc = cyc;
        n_start++;
        check("issue_grant_id", 32'(grant_id), 32'(last_id));
        check("issue_operands", 32'({bus.alu_op, bus.alu_a, bus.alu_b}), 32'(last_req));
      end
      if ((bus.rsp0_valid || bus.rsp1_valid) && !prev_rsp) rsp_cyc = cyc;
      prev_rsp = bus.rsp0_valid || bus.rsp1_valid;
      if ((bus.rsp0_valid && bus.rsp0_ready) || (bus.rsp1_valid && bus.rsp1_ready)) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_exclusive", 32'(bus.rsp0_valid && bus.rsp1_valid), 32'd0);
          check("rsp_id", 32'(bus.rsp1_valid), 32'(e.id));
          check("rsp_result", 32'(bus.rsp1_valid ? bus.rsp1_result : bus.rsp0_result), 32'(e.res));
          check("rsp_err", 32'(bus.rsp1_valid ? bus.rsp1_err : bus.rsp0_err), 32'(e.err));
        end
        n_rsp++;
      end
    end else begin
      prev_rsp = 1'b0;
    end
  end

  task automatic drive(input logic id, input logic v, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    if (id) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end
  endtask

  task automatic send(input logic id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    bit ok = 0;
    @(posedge clk); #1;
    drive(id, 1'b1, op, a, b);
    drv_cyc = cyc;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) begin ok = 1; break; end
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    drive(id, 1'b0, op, a, b);
  endtask

  task automatic wait_rsp(input int target);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (n_rsp >= target) begin ok = 1; break; end
    end
    if (!ok) check("rsp_timeout", 32'(n_rsp), 32'(target));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check({tag, "_alu_start"}, 32'(bus.alu_start), 32'd0);
    check({tag, "_alu_bus"}, 32'({bus.alu_op, bus.alu_a, bus.alu_b}), 32'd0);
    check({tag, "_req_ready"}, 32'({bus.req1_ready, bus.req0_ready}), 32'd0);
    check({tag, "_rsp_valid"}, 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
    check({tag, "_rsp_data"}, 32'({bus.rsp1_result, bus.rsp0_result}), 32'd0);
    check({tag, "_rsp_err"}, 32'({bus.rsp1_err, bus.rsp0_err}), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bit ok;
    drive(1'b0, 1'b0, 4'd0, 8'd0, 8'd0);
    drive(1'b1, 1'b0, 4'd0, 8'd0, 8'd0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    bus.alu_done   = 1'b0;
    bus.alu_result = '0;
    #1;
    check_reset_outputs("reset");
    do_reset();

    // Single req0 ADD 5+3 with done one cycle after start.
    alu_delay = 1;
    base = n_rsp;
    send(1'b0, 4'd0, 8'h05, 8'h03);
    wait_rsp(base + 1);
    check("t1_ready_cycle", 32'(acc_cyc - drv_cyc), 32'd0);
    check("t1_start_latency", 32'(start_cyc - acc_cyc), 32'd1);
    check("t1_rsp_latency", 32'(rsp_cyc - acc_cyc), 32'd3);

    // Both requesters held valid from reset: order 0,1,0,1.
    do_reset();
    acc_ids.delete();
    alu_delay = 3;
    base = n_rsp;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 4'd0, 8'd7, 8'd9);
    drive(1'b1, 1'b1, 4'd1, 8'd20, 8'd5);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (acc_ids.size() >= 4) begin ok = 1; break; end
    end
    if (!ok) check("t2_accept_timeout", 32'(acc_ids.size()), 32'd4);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'd0, 8'd7, 8'd9);
    drive(1'b1, 1'b0, 4'd1, 8'd20, 8'd5);
    for (int i = 0; i < 4; i++)
      check($sformatf("t2_grant_order_%0d", i), 32'(i < acc_ids.size() ? acc_ids[i] : 1'bx), 32'(i % 2));
    wait_rsp(base + 4);

    // ALU never finishes: timeout, then a stray late done, then a normal op.
    alu_delay = 0;
    base = n_rsp;
    send(1'b1, 4'd2, 8'd3, 8'd4);
    wait_rsp(base + 1);
    check("t3_timeout_latency", 32'(rsp_cyc - start_cyc), 32'd17);
    @(posedge clk); #1 inject = 1'b1;
    @(posedge clk); #1 inject = 1'b0;
    repeat (2) @(negedge clk);
    check("t3_late_done_busy", 32'(busy), 32'd0);
    check("t3_late_done_rsp", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
    alu_delay = 2;
    send(1'b0, 4'd1, 8'd50, 8'd8);
    wait_rsp(base + 2);

    // Done arrives exactly on the last WAIT cycle: result wins over timeout.
    alu_delay = TMO;
    base = n_rsp;
    send(1'b0, 4'd2, 8'd15, 8'd17);
    wait_rsp(base + 1);
    check("t4_boundary_latency", 32'(rsp_cyc - start_cyc), 32'd17);

    // Response back-pressure on requester 1 for 10 cycles.
    alu_delay = 2;
    base = n_rsp;
    bus.rsp1_ready = 1'b0;
    send(1'b1, 4'd2, 8'd12, 8'd11);
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.rsp1_valid) begin ok = 1; break; end
    end
    if (!ok) check("t5_rsp_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 4'd0, 8'd1, 8'd2);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_hold_valid", 32'(bus.rsp1_valid), 32'd1);
      check("t5_hold_result", 32'(bus.rsp1_result), 32'h0084);
      check("t5_no_req0_accept", 32'(bus.req0_ready), 32'd0);
      check("t5_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1 bus.rsp1_ready = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req0_ready) begin ok = 1; break; end
    end
    if (!ok) check("t5_req0_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'd0, 8'd1, 8'd2);
    wait_rsp(base + 2);

    // Reset during WAIT abandons the op; afterwards req0 wins a tie.
    alu_delay = 0;
    base = n_rsp;
    send(1'b1, 4'd0, 8'd9, 8'd9);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_mid_reset");
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("t6_no_rsp", 32'(n_rsp), 32'(base));
    alu_delay = 2;
    acc_ids.delete();
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 4'd3, 8'hA5, 8'h0F);
    drive(1'b1, 1'b1, 4'd0, 8'd1, 8'd1);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (acc_ids.size() != 0) begin ok = 1; break; end
    end
    if (!ok) check("t6_accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 4'd3, 8'hA5, 8'h0F);
    drive(1'b1, 1'b0, 4'd0, 8'd1, 8'd1);
    check("t6_first_grant", 32'(acc_ids.size() != 0 ? acc_ids[0] : 1'bx), 32'd0);
    wait_rsp(base + 1);

    repeat (3) @(posedge clk);
    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
